pcpu_imem_loader: RTL and testbench
===================================

Name: pcpu_imem_loader

Overview:
- Instruction-side upstream block for the 16-bit pipeline CPU.
- Holds the 256x16 instruction memory and answers the CPU fetch address with a same-cycle (combinational) read of `i_datain`.
- Accepts a program from a host over a valid/ready word stream.
- After the last word it drives the CPU `enable`/`start` pair to launch execution, and holds `enable` until a host stop.

Parameters:
- ADDR_W, 8, instruction address width; must match CPU `i_addr`.
- DATA_W, 16, instruction word width.
- DEPTH, 256, memory words (2**ADDR_W).

Ports:
- reset  input  1  asynchronous, active-low reset
- clock  input  1  rising-edge clock
- host_valid  input  1  host word valid
- host_data  input  DATA_W  host instruction word
- host_last  input  1  marks final word of the program
- host_ready  output  1  loader can accept a word this cycle
- stop  input  1  host request to stop the CPU or abort a load
- i_addr  input  ADDR_W  CPU fetch address (CPU pc)
- i_datain  output  DATA_W  instruction at i_addr, combinational
- enable  output  1  CPU enable, registered
- start  output  1  CPU start, one-cycle registered pulse
- busy  output  1  state != IDLE
- load_count  output  ADDR_W+1  words accepted in the current or last load (0..256)
- checksum  output  DATA_W  mod-2^16 sum of the words accepted in the current or last load
- overflow  output  1  load filled DEPTH words without host_last

Behaviour:
- Reset (async, active-low) values:
  - state=IDLE, wr_ptr=0.
  - host_ready=0, enable=0, start=0, busy=0.
  - load_count=0, checksum=0, overflow=0.
  - Memory contents are not reset.
- Accept event: host_valid && host_ready at a rising edge.
  - mem[wr_ptr] <= host_data; wr_ptr++; load_count++; checksum += host_data (wraps mod 2^16).
- host_ready is combinational: 1 in IDLE and LOAD, 0 in ARM and RUN.
- IDLE:
  - enable=0, start=0.
  - On an accept: if it is the first word of a new load, load_count, checksum and overflow are cleared before that word is counted. The written word lands at address 0, so the result is load_count=1 and checksum=host_data.
  - Then go to LOAD, or go straight to ARM if host_last is set on that word.
  - stop in IDLE is ignored.
- LOAD:
  - Accept words as above.
  - An accept with host_last -> ARM.
  - An accept with wr_ptr==DEPTH-1 and no host_last -> ARM with overflow<=1. The word is still written, load_count=256, and wr_ptr wraps to 0.
  - stop=1 -> IDLE, abort, no launch. If stop coincides with an accept, the word is still written and counted, but stop wins over host_last.
- ARM:
  - Lasts one cycle. Registered enable=1 and start=1 are visible in this cycle, so the CPU sees enable && start together.
  - Next state is RUN. stop during ARM is honoured in RUN on the following cycle.
- RUN:
  - enable=1, start=0.
  - stop=1 -> IDLE; enable drops to 0 at that edge.
  - The CPU self-halts internally; the loader does not observe the halt and keeps enable=1 until stop.
- Register outputs:
  - enable <= (next_state==ARM || next_state==RUN).
  - start <= (next_state==ARM).
- Read path: i_datain = mem[i_addr] in every state. It reads pre-write data for the address written in the same cycle (no write-through).
- A new load after RUN->IDLE overwrites from address 0. Words beyond the new load_count keep old contents.
- Reset mid-load or mid-run: state returns to IDLE immediately and enable/start drop asynchronously. Partially written memory is kept.

Test Plan:
- Reset, then load 4 words 0x1100,0x2201,0x3302,0x0800 with host_last on word 4 -> load_count=4, checksum=0x6E03. One cycle later enable=1 and start=1 for exactly one cycle; i_addr=0..3 returns those words.
- Host deasserts host_valid mid-load (gap of 3 cycles) -> no writes during the gap, load_count unchanged, state stays LOAD, host_ready stays 1.
- Stream 256 words of value 0x0101 with no host_last -> overflow=1, load_count=256, checksum=0x0100, ARM entered, wr_ptr back to 0.
- In RUN assert stop for 1 cycle -> enable=0 at the next edge, busy=0, host_ready=1. A new 2-word load then gives load_count=2 and new checksum; address 2 keeps the old word.
- stop asserted together with the host_last accept -> word written, load_count includes it, state IDLE, start never pulses.
- Async reset asserted during LOAD after 3 words -> enable/start/busy/load_count/checksum all 0 immediately; mem[0..2] still read back the loaded words.

Source files
------------

// File: rtl/pcpu_imem_loader.sv
// pcpu_imem_loader: instruction memory plus host program loader for the
// 16-bit pipeline CPU. The host streams words into the memory, then the
// loader launches the CPU with an enable/start pair and keeps it enabled
// until the host asks it to stop. Fetch reads are combinational.
module pcpu_imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              reset,
    input  logic              clock,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic              stop,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    output logic              enable,
    output logic              start,
    output logic              busy,
    output logic [ADDR_W:0]   load_count,
    output logic [DATA_W-1:0] checksum,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;
    logic              ptr_at_end;
    logic              overflow_hit;
    logic [DATA_W-1:0] mem [DEPTH];

    // A word is taken whenever the host offers one and we are ready.
    assign accept = host_valid && host_ready;

    // Every new load starts at address 0, whatever wr_ptr was left at.
    assign wr_addr = (state == IDLE) ? '0 : wr_ptr;

    assign ptr_at_end = (wr_ptr == ADDR_W'(DEPTH - 1));

    // Filling the last location without host_last ends the load as overflow;
    // a coincident stop aborts instead.
    assign overflow_hit = (state == LOAD) && accept && !stop && !host_last && ptr_at_end;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = host_last ? ARM : LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (accept && (host_last || ptr_at_end)) begin
                    next_state = ARM;
                end
            end
            ARM: begin
                next_state = RUN;
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Combinational handshake and status outputs; nothing is accepted in reset.
    always_comb begin
        host_ready = 1'b0;
        busy       = 1'b0;
        if (reset && (state == IDLE || state == LOAD)) begin
            host_ready = 1'b1;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // Registered CPU launch controls, derived from where the FSM is heading.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable <= 1'b0;
            start  <= 1'b0;
        end else begin
            enable <= (next_state == ARM) || (next_state == RUN);
            start  <= (next_state == ARM);
        end
    end

    // Write pointer and load statistics; the first word of a load restarts them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            load_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_addr + ADDR_W'(1);
            if (state == IDLE) begin
                load_count <= (ADDR_W + 1)'(1);
                checksum   <= host_data;
                overflow   <= 1'b0;
            end else begin
                load_count <= load_count + (ADDR_W + 1)'(1);
                checksum   <= checksum + host_data;
                if (overflow_hit) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_addr] <= host_data;
        end
    end

    assign i_datain = mem[i_addr];

endmodule

// File: tb/tb_pcpu_imem_loader.sv
// tb_pcpu_imem_loader: randomized bench for pcpu_imem_loader with a
// word-array reference of the instruction memory and load statistics.
module tb_pcpu_imem_loader;

    logic        reset;
    logic        clock;
    logic        host_valid;
    logic [15:0] host_data;
    logic        host_last;
    logic        host_ready;
    logic        stop;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic        enable;
    logic        start;
    logic        busy;
    logic [8:0]  load_count;
    logic [15:0] checksum;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem   [256];
    bit          ref_known [256];
    logic [15:0] prog [$];
    int          exp_count;
    logic [15:0] exp_sum;

    pcpu_imem_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut (
        .reset      (reset),
        .clock      (clock),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .stop       (stop),
        .i_addr     (i_addr),
        .i_datain   (i_datain),
        .enable     (enable),
        .start      (start),
        .busy       (busy),
        .load_count (load_count),
        .checksum   (checksum),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, load_count, 0);
        chk({tag, "_sum"}, checksum, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_ready"}, host_ready, 0);
    endtask

    task automatic readback(input string tag);
        host_valid = 0;
        stop = 0;
        for (int a = 0; a < 256; a++) begin
            if (ref_known[a]) begin
                i_addr = a[7:0];
                #1;
                chk(tag, i_datain, ref_mem[a]);
            end
        end
    endtask

    // Streams prog[] to the loader, with random idle gaps (fixed 3-cycle gap
    // before word gap_idx), and checks the statistics after every word.
    task automatic load_prog(input int gap_idx, input int max_gap, input bit with_last,
                             input bit stop_last);
        int          n;
        int          g;
        logic [15:0] sum;
        bit          exp_ovf;
        n   = prog.size();
        sum = 16'h0;
        for (int i = 0; i < n; i++) begin
            g = (i == gap_idx) ? 3 : $urandom_range(0, max_gap);
            for (int k = 0; k < g; k++) begin
                host_valid = 0;
                host_data  = 16'($urandom);
                host_last  = 1'($urandom);
                tick();
                if (i > 0) begin
                    chk("gap_count", load_count, i);
                    chk("gap_ready", host_ready, 1);
                    chk("gap_busy", busy, 1);
                end
            end
            host_valid = 1;
            host_data  = prog[i];
            host_last  = with_last && (i == n - 1);
            stop       = stop_last && (i == n - 1);
            i_addr     = 8'(i % 256);
            #1;
            chk("ready_before_accept", host_ready, 1);
            if (ref_known[i % 256]) chk("read_before_write", i_datain, ref_mem[i % 256]);
            tick();
            ref_mem[i % 256]   = prog[i];
            ref_known[i % 256] = 1'b1;
            sum = sum + prog[i];
            chk("count", load_count, i + 1);
            chk("sum", checksum, sum);
            host_valid = 0;
            host_last  = 0;
            stop       = 0;
        end
        exp_count = n;
        exp_sum   = sum;
        exp_ovf   = (n == 256) && !with_last && !stop_last;
        chk("end_ovf", overflow, exp_ovf);
        if (stop_last) begin
            chk("abort_busy", busy, 0);
            chk("abort_enable", enable, 0);
            chk("abort_start", start, 0);
            chk("abort_ready", host_ready, 1);
        end else if (with_last || n == 256) begin
            chk("arm_enable", enable, 1);
            chk("arm_start", start, 1);
            chk("arm_busy", busy, 1);
            chk("arm_ready", host_ready, 0);
        end else begin
            chk("load_busy", busy, 1);
            chk("load_ready", host_ready, 1);
            chk("load_enable", enable, 0);
        end
    endtask

    // CPU running: host traffic must be ignored and enable held.
    task automatic run_cycles(input int k);
        for (int c = 0; c < k; c++) begin
            host_valid = 1'($urandom);
            host_data  = 16'($urandom);
            host_last  = 1'($urandom);
            tick();
            chk("run_enable", enable, 1);
            chk("run_start", start, 0);
            chk("run_ready", host_ready, 0);
            chk("run_busy", busy, 1);
            chk("run_count", load_count, exp_count);
            chk("run_sum", checksum, exp_sum);
        end
        host_valid = 0;
        host_last  = 0;
    endtask

    task automatic stop_run();
        host_valid = 0;
        stop = 1;
        tick();
        stop = 0;
        chk("stop_enable", enable, 0);
        chk("stop_busy", busy, 0);
        chk("stop_ready", host_ready, 1);
        chk("stop_start", start, 0);
    endtask

    initial begin
        int n;
        reset = 0;
        host_valid = 0;
        host_data = 0;
        host_last = 0;
        stop = 0;
        i_addr = 0;
        for (int a = 0; a < 256; a++) ref_known[a] = 1'b0;

        #12;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1;
        tick();
        chk("idle_ready", host_ready, 1);
        chk("idle_busy", busy, 0);

        // Known program with a 3-cycle host gap before word 2.
        prog = '{16'h1100, 16'h2201, 16'h3302, 16'h0800};
        load_prog(2, 0, 1, 0);
        chk("plan_count", load_count, 4);
        chk("plan_sum", checksum, 16'h6E03);
        run_cycles(1);
        readback("plan_read");
        stop_run();

        // Short reload keeps the old word at address 2.
        prog = '{16'($urandom), 16'($urandom)};
        load_prog(-1, 1, 1, 0);
        chk("reload_count", load_count, 2);
        run_cycles(2);
        i_addr = 8'd2;
        #1;
        chk("keep_addr2", i_datain, 16'h3302);
        stop_run();

        // Random programs.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 40);
            prog = {};
            for (int i = 0; i < n; i++) prog.push_back(16'($urandom));
            load_prog(-1, 2, 1, 0);
            run_cycles($urandom_range(1, 5));
            readback("rand_read");
            stop_run();
        end

        // stop in IDLE is ignored.
        stop = 1;
        tick();
        stop = 0;
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_count", load_count, exp_count);

        // Full memory without host_last.
        prog = {};
        for (int i = 0; i < 256; i++) prog.push_back(16'h0101);
        load_prog(-1, 0, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", load_count, 256);
        chk("ovf_sum", checksum, 16'h0100);
        run_cycles(2);
        stop_run();

        // Next load clears overflow and restarts at address 0.
        prog = '{16'hBEEF};
        load_prog(-1, 0, 1, 0);
        chk("after_ovf_count", load_count, 1);
        run_cycles(1);
        readback("after_ovf_read");
        stop_run();

        // stop together with the final accept: counted, no launch.
        prog = '{16'($urandom), 16'($urandom), 16'($urandom)};
        load_prog(-1, 1, 1, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stoplast_start", start, 0);
            chk("stoplast_enable", enable, 0);
        end
        readback("stoplast_read");

        // Abort a load with stop while no word is offered.
        prog = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        load_prog(-1, 1, 0, 0);
        stop = 1;
        tick();
        stop = 0;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_count", load_count, 5);
        chk("abort_idle_enable", enable, 0);

        // Asynchronous reset in the middle of a load.
        prog = '{16'($urandom), 16'($urandom), 16'($urandom)};
        load_prog(-1, 1, 0, 0);
        host_valid = 1;
        host_data  = 16'($urandom);
        #2;
        reset = 0;
        #1;
        chk_all_zero("rst_load");
        host_valid = 0;
        @(negedge clock);
        reset = 1;
        tick();
        readback("rst_load_read");

        // Asynchronous reset while the CPU is running.
        prog = '{16'($urandom), 16'($urandom)};
        load_prog(-1, 0, 1, 0);
        run_cycles(2);
        #2;
        reset = 0;
        #1;
        chk_all_zero("rst_run");
        @(negedge clock);
        reset = 1;
        tick();
        readback("rst_run_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
